// File: rtl/defast_copy_dict.sv
// defast_copy_dict: FAST copy-operator decoder stage with a shared per-field dictionary
// Decodes up to NUM_CH presence-map-encoded messages per beat. Present fields update the
// dictionary. Absent fields take their value from the dictionary. Later channels in a
// beat see the dictionary writes made by earlier channels. The output is registered
// behind a valid/ready handshake.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            input beat handshake
//   in_ch_valid, in_msg          per-channel message present, packed messages
//   dict_clr                     dictionary clear pulse, applied before a coincident beat
//   out_valid/out_ready          output beat handshake
//   out_ch_valid, out_msg        registered channel valids, decoded messages
//   out_bad, bad_cnt             per-channel malformed flag, saturating bad-message count
// Optional feature: define DEFAST_UNDEF_CHECK_EN to flag absent fields whose dictionary
// entry has never been assigned.
module defast_copy_dict #(
    parameter int NUM_CH     = 3,
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 8,
    parameter int PAYLOAD_W  = 64,
    parameter int PMAP_W     = 16,
    localparam int OUT_W     = NUM_FIELDS*FIELD_W + PAYLOAD_W,
    localparam int IN_W      = PMAP_W + OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH-1:0]       in_ch_valid,
    input  logic [NUM_CH*IN_W-1:0]  in_msg,
    input  logic                    dict_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH-1:0]       out_ch_valid,
    output logic [NUM_CH*OUT_W-1:0] out_msg,
    output logic [NUM_CH-1:0]       out_bad,
    output logic [15:0]             bad_cnt
);
    // pmap bits below the field-presence bits must be zero
    localparam logic [PMAP_W-1:0] LOW_MASK = {PMAP_W{1'b1}} >> (NUM_FIELDS + 1);
    logic [NUM_FIELDS-1:0][FIELD_W-1:0] dict, dict_n;
    logic [NUM_CH*OUT_W-1:0] msg_n;
    logic [NUM_CH-1:0] bad_n;
    logic [IN_W-1:0] m;
    logic [OUT_W-1:0] sh, o;
    logic [16:0] sum;
    logic acc, bad;
    int off;
`ifdef DEFAST_UNDEF_CHECK_EN
    logic [NUM_FIELDS-1:0] asg, asg_n;
`endif
    assign in_ready = !out_valid || out_ready;
    assign acc = in_valid && in_ready;
    assign sum = {1'b0, bad_cnt} + 17'($countones(bad_n));
    // Channels are decoded in ascending order against a running dictionary copy,
    // so each channel sees the writes of the channels before it.
    always_comb begin
        dict_n = dict_clr ? '0 : dict;
`ifdef DEFAST_UNDEF_CHECK_EN
        asg_n = dict_clr ? '0 : asg;
`endif
        msg_n = '0;
        bad_n = '0;
        m = '0;
        sh = '0;
        o = '0;
        bad = 1'b0;
        off = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m = in_msg[c*IN_W +: IN_W];
            bad = !m[IN_W-1] || ((m[IN_W-1 -: PMAP_W] & LOW_MASK) != '0);
            o = '0;
            off = 0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                sh = m[OUT_W-1:0] << off;
                if (m[IN_W-2-i]) begin
                    o[OUT_W-1-i*FIELD_W -: FIELD_W] = sh[OUT_W-1 -: FIELD_W];
                    off = off + FIELD_W;
                end else begin
                    o[OUT_W-1-i*FIELD_W -: FIELD_W] = dict_n[i];
`ifdef DEFAST_UNDEF_CHECK_EN
                    bad = bad || !asg_n[i];
`endif
                end
            end
            sh = m[OUT_W-1:0] << off;
            o[PAYLOAD_W-1:0] = sh[OUT_W-1 -: PAYLOAD_W];
            bad_n[c] = in_ch_valid[c] && bad;
            if (acc && in_ch_valid[c] && !bad) begin
                msg_n[c*OUT_W +: OUT_W] = o;
                for (int i = 0; i < NUM_FIELDS; i++)
                    if (m[IN_W-2-i]) begin
                        dict_n[i] = o[OUT_W-1-i*FIELD_W -: FIELD_W];
`ifdef DEFAST_UNDEF_CHECK_EN
                        asg_n[i] = 1'b1;
`endif
                    end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_ch_valid <= '0;
            out_msg      <= '0;
            out_bad      <= '0;
            bad_cnt      <= '0;
            dict         <= '0;
        end else begin
            dict <= dict_n;
            if (in_ready)
                out_valid <= in_valid;
            if (acc) begin
                out_ch_valid <= in_ch_valid;
                out_msg      <= msg_n;
                out_bad      <= bad_n;
                bad_cnt      <= sum[16] ? 16'hFFFF : sum[15:0];
            end
        end
    end
`ifdef DEFAST_UNDEF_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            asg <= '0;
        else
            asg <= asg_n;
    end
`endif
endmodule
